// File: rtl/ws2812_pulse_regen.sv
// ws2812_pulse_regen: multi-channel WS2812 pulse qualifier, bit classifier and fixed-width regenerator
module ws2812_pulse_regen #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 12,
    parameter int GLITCH_CYC = 3,
    parameter int T0H_NOM    = 20,
    parameter int T1H_MIN    = 30,
    parameter int T1H_NOM    = 40,
    parameter int MAX_HIGH   = 100,
    parameter int RESET_CYC  = 2500
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_signal_synced,
    input  logic [N_CH-1:0] i_reshape_en,
    input  logic [N_CH-1:0] i_out_en,
    output logic [N_CH-1:0] o_signal,
    output logic [N_CH-1:0] o_bit_strobe,
    output logic [N_CH-1:0] o_bit_value,
    output logic [N_CH-1:0] o_latch,
    output logic [N_CH-1:0] o_glitch,
    output logic [N_CH-1:0] o_fault
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_QUAL  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(GLITCH_CYC - 1);
    localparam logic [CNT_W-1:0] T0_NOM = CNT_W'(T0H_NOM);
    localparam logic [CNT_W-1:0] T1_MIN = CNT_W'(T1H_MIN);
    localparam logic [CNT_W-1:0] T1_NOM = CNT_W'(T1H_NOM);
    localparam logic [CNT_W-1:0] MAX_H  = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(RESET_CYC - 1);

    if (GLITCH_CYC < 1 || T0H_NOM >= T1H_MIN || T1H_MIN > T1H_NOM || T1H_NOM >= MAX_HIGH ||
        MAX_HIGH >= (1 << CNT_W) || RESET_CYC >= (1 << CNT_W)) begin : g_param_check
        $error("ws2812_pulse_regen: inconsistent timing parameters");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [2:0] st;
        logic [CNT_W-1:0] qcnt, hcnt, lcnt;
        logic bit0, sig, strobe, value, latch, glitch, fault;
        logic x, en, nb0, done, stuck;
        assign x = i_signal_synced[c];
        assign en = i_out_en[c];
        // a fall before the bit-1 threshold marks the pulse as bit 0 for good
        assign nb0 = bit0 || (!x && hcnt < T1_MIN);
        assign done = nb0 ? hcnt >= T0_NOM : !x && hcnt >= T1_NOM;
        assign stuck = !nb0 && hcnt >= MAX_H;
        always_ff @(posedge i_clk) begin
            strobe <= 1'b0;
            latch <= 1'b0;
            glitch <= 1'b0;
            sig <= 1'b0;
            if (i_reset || !i_reshape_en[c]) begin
                st <= S_IDLE;
                qcnt <= '0;
                hcnt <= '0;
                lcnt <= '0;
                bit0 <= 1'b0;
                value <= 1'b0;
                fault <= 1'b0;
                sig <= !i_reset && x && en;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (x) begin
                            st <= S_QUAL;
                            qcnt <= ONE;
                        end
                    end
                    S_QUAL: begin
                        if (!x) begin
                            st <= S_IDLE;
                            glitch <= 1'b1;
                        end else if (qcnt >= Q_LAST) begin
                            st <= S_HIGH;
                            sig <= en;
                            hcnt <= ONE;
                            bit0 <= 1'b0;
                        end else begin
                            qcnt <= qcnt + ONE;
                        end
                    end
                    S_HIGH: begin
                        bit0 <= nb0;
                        if (done) begin
                            st <= S_LOW;
                            strobe <= 1'b1;
                            value <= !nb0;
                            lcnt <= '0;
                        end else if (stuck) begin
                            st <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            hcnt <= hcnt + ONE;
                            sig <= en;
                        end
                    end
                    S_LOW: begin
                        if (x) begin
                            st <= S_QUAL;
                            qcnt <= ONE;
                        end else if (lcnt >= L_LAST) begin
                            st <= S_IDLE;
                            latch <= 1'b1;
                        end else begin
                            lcnt <= lcnt + ONE;
                        end
                    end
                    S_FAULT: begin
                        if (!x) begin
                            st <= S_LOW;
                            lcnt <= '0;
                            fault <= 1'b0;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
        assign o_signal[c] = sig;
        assign o_bit_strobe[c] = strobe;
        assign o_bit_value[c] = value;
        assign o_latch[c] = latch;
        assign o_glitch[c] = glitch;
        assign o_fault[c] = fault;
    end
endmodule

// File: tb/tb_ws2812_pulse_regen.sv
// tb_ws2812_pulse_regen: randomized pulse-train bench with per-channel event scoreboard
module tb_ws2812_pulse_regen;
    localparam int N = 4;
    localparam int GC = 3, T0H = 20, T1MIN = 30, T1H = 40, MAXH = 100, RC = 2500;
    localparam int K_RISE = 0, K_FALL = 1, K_STB = 2, K_FUP = 3, K_FDN = 4, K_LAT = 5, K_GL = 6;

    typedef struct packed {
        int kind;
        int at;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] sig_in = '0;
    logic [N-1:0] reshape_en = '1;
    logic [N-1:0] out_en = '1;
    logic [N-1:0] o_signal, o_bit_strobe, o_bit_value, o_latch, o_glitch, o_fault;
    logic [N-1:0] p_sig = '0;
    logic [N-1:0] p_fault = '0;
    ev_t evq[N][$];
    int item_w[N][$];
    int item_l[N][$];
    int hi_rem[N], lo_rem[N], pend_e[N];
    bit prev_x[N];
    int edge_n = 0, total = 0, bad = 0, byp = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ws2812_pulse_regen dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_signal_synced(sig_in),
        .i_reshape_en(reshape_en),
        .i_out_en(out_en),
        .o_signal(o_signal),
        .o_bit_strobe(o_bit_strobe),
        .o_bit_value(o_bit_value),
        .o_latch(o_latch),
        .o_glitch(o_glitch),
        .o_fault(o_fault)
    );

    function automatic void push(int c, int kind, int at, int val);
        ev_t e;
        e.kind = kind;
        e.at = at;
        e.val = val;
        evq[c].push_back(e);
    endfunction

    // Expected events of one input pulse of width w whose first high sample is edge k.
    // Output rises after GC qualifying samples; w-(GC-1) is the high time seen after that.
    function automatic void plan(int c, int k, int w);
        int e;
        bit one;
        if (w < GC) begin
            push(c, K_GL, k + w, 0);
            pend_e[c] = -1;
            return;
        end
        if (out_en[c]) push(c, K_RISE, k + GC - 1, 0);
        if (w >= MAXH + GC) begin
            if (out_en[c]) push(c, K_FALL, k + MAXH + GC - 1, 0);
            push(c, K_FUP, k + MAXH + GC - 1, 0);
            push(c, K_FDN, k + w, 0);
            e = k + w;
        end else begin
            one = (w - (GC - 1)) >= T1MIN;
            e = one ? k + ((w > T1H + GC - 1) ? w : T1H + GC - 1) : k + T0H + GC - 1;
            if (out_en[c]) push(c, K_FALL, e, 0);
            push(c, K_STB, e, int'(one));
        end
        pend_e[c] = e;
    endfunction

    function automatic void add(int c, int w, int l);
        item_w[c].push_back(w);
        item_l[c].push_back(l);
    endfunction

    function automatic void add_rand(int c);
        int r, w, l;
        r = int'($urandom_range(19, 0));
        if (r < 3) w = int'($urandom_range(2, 1));
        else if (r < 9) w = int'($urandom_range(22, 3));
        else if (r < 18) w = int'($urandom_range(102, 32));
        else w = int'($urandom_range(140, 103));
        l = ($urandom_range(5, 0) == 0) ? int'($urandom_range(2506, 2495)) : int'($urandom_range(120, 45));
        add(c, w, l);
    endfunction

    function automatic bit busy();
        for (int c = 0; c < N; c++)
            if (item_w[c].size() > 0 || hi_rem[c] > 0 || lo_rem[c] > 0 || evq[c].size() > 0 || pend_e[c] >= 0)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic void check(int c, int kind, int val);
        ev_t e;
        total++;
        if (evq[c].size() == 0) begin
            bad++;
            $display("FAIL unexpected ch%0d: got kind=%0d val=%0d at edge %0d, required no event", c, kind, val, edge_n);
        end else begin
            e = evq[c].pop_front();
            if (e.kind != kind || e.at != edge_n || e.val != val) begin
                bad++;
                $display("FAIL event ch%0d: got kind=%0d edge=%0d val=%0d, required kind=%0d edge=%0d val=%0d",
                         c, kind, edge_n, val, e.kind, e.at, e.val);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < N; c++) begin
                while (evq[c].size() > 0 && evq[c][0].at < edge_n) begin
                    total++;
                    bad++;
                    $display("FAIL missing ch%0d kind=%0d: absent by edge %0d, required at edge %0d",
                             c, evq[c][0].kind, edge_n, evq[c][0].at);
                    void'(evq[c].pop_front());
                end
                if (o_signal[c] && !p_sig[c]) check(c, K_RISE, 0);
                if (!o_signal[c] && p_sig[c]) check(c, K_FALL, 0);
                if (o_bit_strobe[c]) check(c, K_STB, int'(o_bit_value[c]));
                if (o_fault[c] && !p_fault[c]) check(c, K_FUP, 0);
                if (!o_fault[c] && p_fault[c]) check(c, K_FDN, 0);
                if (o_latch[c]) check(c, K_LAT, 0);
                if (o_glitch[c]) check(c, K_GL, 0);
            end
        end
        p_sig = o_signal;
        p_fault = o_fault;
    end

    // One clock: inputs set here are sampled at edge edge_n+1.
    task automatic step();
        @(posedge clk);
        edge_n++;
        #1;
        for (int c = 0; c < N; c++) begin
            bit x;
            if (byp != 0) begin
                x = (byp == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
                if (x != prev_x[c]) push(c, x ? K_RISE : K_FALL, edge_n + 1, 0);
                prev_x[c] = x;
            end else begin
                if (hi_rem[c] == 0 && lo_rem[c] == 0 && item_w[c].size() > 0) begin
                    hi_rem[c] = item_w[c].pop_front();
                    lo_rem[c] = item_l[c].pop_front();
                    plan(c, edge_n + 1, hi_rem[c]);
                end
                x = hi_rem[c] > 0;
                if (x) hi_rem[c]--;
                else if (lo_rem[c] > 0) lo_rem[c]--;
                if (!x && pend_e[c] >= 0 && edge_n + 1 == pend_e[c] + RC) begin
                    push(c, K_LAT, edge_n + 1, 0);
                    pend_e[c] = -1;
                end
            end
            sig_in[c] = x;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        total++;
        if (busy()) begin
            bad++;
            $display("FAIL drain: stimulus or expected events still pending after %0d cycles, required none", budget);
        end
    endtask

    task automatic check_quiet(input string name);
        total++;
        if ({o_signal, o_bit_strobe, o_bit_value, o_latch, o_glitch, o_fault} !== '0) begin
            bad++;
            $display("FAIL %s: outputs sig=%b stb=%b val=%b lat=%b gl=%b flt=%b, required all 0",
                     name, o_signal, o_bit_strobe, o_bit_value, o_latch, o_glitch, o_fault);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded cycle limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            pend_e[c] = -1;
            hi_rem[c] = 0;
            lo_rem[c] = 0;
            prev_x[c] = 1'b0;
        end
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        add(0, 10, 60);
        add(1, 35, 60);
        add(1, 60, 60);
        add(2, 2, 60);
        add(2, 3, 60);
        add(3, 200, 2600);
        add(3, 60, 2500);
        add(3, 60, 2501);
        add(3, 5, 50);
        for (int c = 0; c < N; c++)
            for (int i = 0; i < 8; i++) add_rand(c);
        drain(40000);

        out_en = '0;
        for (int c = 0; c < N; c++)
            for (int i = 0; i < 6; i++) add_rand(c);
        drain(20000);
        out_en = '1;

        add(0, 60, 60);
        repeat (28) step();
        total++;
        if (o_signal[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_high: o_signal[0]=%b, required 1", o_signal[0]);
        end
        for (int c = 0; c < N; c++) begin
            evq[c].delete();
            item_w[c].delete();
            item_l[c].delete();
            hi_rem[c] = 0;
            lo_rem[c] = 0;
            pend_e[c] = -1;
        end
        mon_en = 1'b0;
        rst = 1'b1;
        step();
        check_quiet("reset_mid_high");
        rst = 1'b0;
        reshape_en = '0;
        byp = 1;
        step();
        mon_en = 1'b1;
        repeat (150) step();
        byp = 2;
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
